data_memory_stage: RTL and testbench

DATA_MEMORY_STAGE -- requirements
Module: data_memory_stage

---
 rtl/dm_pkg.sv | 33 +++
 rtl/dm_byte_ram.sv | 39 +++
 rtl/data_memory_stage.sv | 207 ++++++++++++++++++++
 tb/tb_data_memory_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared definitions for the data memory pipeline stage: FSM
//            state encoding, default parameter values and lane helpers.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

  // Default configuration of data_memory_stage
  localparam int c_data_w_def      = 16;
  localparam int c_addr_w_def      = 8;
  localparam int c_wait_cycles_def = 1;

  // Access FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  // Number of byte lanes in a word of data_w bits
  function automatic int dm_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-address bits that select a lane inside a word
  function automatic int dm_lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : dm_byte_ram
// Purpose  : Word-addressed RAM built from independent byte lanes, with a
//            write enable per lane and an asynchronous (combinational) read.
// Ports    : clk      - clock, writes on the rising edge
//            i_we     - per-lane write enables
//            i_addr   - word address (shared by write and read)
//            i_wdata  - write data, lane g on bits [8g+7:8g]
//            o_rdata  - read data of the addressed word
// Revision : 1.0 - initial release
// ============================================================================
module dm_byte_ram #(
  parameter int LANES  = 2,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     i_we,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [LANES*8-1:0]   i_wdata,
  output logic [LANES*8-1:0]   o_rdata
);

  localparam int c_depth = 2 ** ADDR_W;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
      if (i_we[g]) begin
        r_mem[i_addr] <= i_wdata[g*8 +: 8];
      end
    end

    assign o_rdata[g*8 +: 8] = r_mem[i_addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_stage
// Purpose  : Pipeline memory stage. A request in IDLE is captured, waits a
//            fixed number of cycles, then performs a word or byte-lane access
//            on an internal byte RAM and returns the result on ans_dm with a
//            one-cycle dm_valid pulse. Without a request the ALU result is
//            passed straight through in one cycle.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            ans_ex          - byte address (memory op) or pass-through value
//            DM_data         - store data
//            mem_en_ex       - memory access request
//            mem_rw_ex       - 1 = write, 0 = read
//            mem_byte_ex     - 1 = byte access, 0 = full word
//            mem_mux_sel_dm  - 1 = result is read data, 0 = captured ans_ex
//            ans_dm          - registered stage result
//            dm_valid        - registered pulse when ans_dm updates
//            dm_busy         - stall, high while the FSM is not IDLE
//            dm_fault        - registered access fault flag
// Options  : DM_FAULT_EN - when defined, out-of-range addresses and
//            misaligned word accesses are reported as faults and suppressed.
//            When undefined, the address wraps and dm_fault stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_stage
  import dm_pkg::*;
#(
  parameter int DATA_W      = c_data_w_def,
  parameter int ADDR_W      = c_addr_w_def,
  parameter int WAIT_CYCLES = c_wait_cycles_def
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_byte_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm,
  output logic              dm_valid,
  output logic              dm_busy,
  output logic              dm_fault
);

  localparam int         c_lanes = dm_lanes(DATA_W);
  localparam int         c_l     = dm_lane_bits(DATA_W);
  localparam logic [3:0] c_wait  = 4'(WAIT_CYCLES);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  dm_state_e           r_state;
  dm_state_e           w_next_state;
  logic [3:0]          r_cnt;

  // Request captured in IDLE; held stable for the whole access
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rw;
  logic                r_byte;
  logic                r_sel;

  logic [DATA_W-1:0]   r_ans_dm;
  logic                r_valid;
  logic                r_fault;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [c_l-1:0]      w_lane;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_fault;

  assign w_lane = r_addr[c_l-1:0];
  assign w_idx  = r_addr[ADDR_W+c_l-1:c_l];

`ifdef DM_FAULT_EN
  logic w_upper_nz;

  if (DATA_W > ADDR_W + c_l) begin : g_upper
    assign w_upper_nz = |r_addr[DATA_W-1:ADDR_W+c_l];
  end else begin : g_no_upper
    assign w_upper_nz = 1'b0;
  end

  // Word accesses must be aligned; byte accesses may use any lane
  assign w_fault = w_upper_nz | (~r_byte & (|w_lane));
`else
  assign w_fault = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // RAM interface
  // --------------------------------------------------------------------------
  logic                w_do_write;
  logic [c_lanes-1:0]  w_we;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic [7:0]          w_lane_rd;
  logic [DATA_W-1:0]   w_rd_val;

  // Writes commit only at the RESP edge; a reset on that edge drops them
  assign w_do_write  = (r_state == ST_RESP) & r_rw & ~w_fault & ~reset;
  assign w_we        = !w_do_write ? '0 :
                       r_byte      ? (c_lanes'(1) << w_lane) : '1;
  // Byte stores replicate the low byte; the lane enable picks the target
  assign w_ram_wdata = r_byte ? {c_lanes{r_wdata[7:0]}} : r_wdata;

  assign w_lane_rd   = w_rdata[{w_lane, 3'b000} +: 8];
  assign w_rd_val    = r_byte ? DATA_W'(w_lane_rd) : w_rdata;

  dm_byte_ram #(
    .LANES  (c_lanes),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_en_ex) begin
          w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_ans_dm <= '0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_en_ex) begin
            r_addr  <= ans_ex;
            r_wdata <= DM_data;
            r_rw    <= mem_rw_ex;
            r_byte  <= mem_byte_ex;
            r_sel   <= mem_mux_sel_dm;
            r_cnt   <= c_wait;
          end else begin
            r_ans_dm <= ans_ex;
            r_valid  <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          r_cnt   <= '0;
          r_valid <= 1'b1;
          if (w_fault) begin
            r_ans_dm <= '0;
            r_fault  <= 1'b1;
          end else if (r_rw || !r_sel) begin
            r_ans_dm <= r_addr;
          end else begin
            r_ans_dm <= w_rd_val;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign ans_dm   = r_ans_dm;
  assign dm_valid = r_valid;
  assign dm_busy  = (r_state != ST_IDLE);
  assign dm_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_stage
// Purpose  : Self-checking bench for data_memory_stage (DATA_W=16, ADDR_W=8,
//            WAIT_CYCLES=1). A driver issues directed and random operations
//            and pushes expected results; a monitor compares every dm_valid
//            response against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_stage;

  localparam int c_wait = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ans_ex = '0;
  logic [15:0] DM_data = '0;
  logic        mem_en_ex = 1'b0;
  logic        mem_rw_ex = 1'b0;
  logic        mem_byte_ex = 1'b0;
  logic        mem_mux_sel_dm = 1'b0;
  logic [15:0] ans_dm;
  logic        dm_valid;
  logic        dm_busy;
  logic        dm_fault;

  data_memory_stage #(
    .DATA_W      (16),
    .ADDR_W      (8),
    .WAIT_CYCLES (c_wait)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ans_ex         (ans_ex),
    .DM_data        (DM_data),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_byte_ex    (mem_byte_ex),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .ans_dm         (ans_dm),
    .dm_valid       (dm_valid),
    .dm_busy        (dm_busy),
    .dm_fault       (dm_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic        f;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem [256];
  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (mon_en && dm_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got ans_dm=0x%04h expected no response at %0t", ans_dm, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ans_dm", ans_dm, e.v);
        check("dm_fault", {15'd0, dm_fault}, {15'd0, e.f});
      end
    end
  end

  // Reference behaviour of one memory access from the address/lane rules
  function automatic logic is_fault(input logic [15:0] a, input logic byte_acc);
`ifdef DM_FAULT_EN
    return (a[15:9] != 7'd0) || (!byte_acc && a[0]);
`else
    return 1'b0 & a[0] & byte_acc;
`endif
  endfunction

  task automatic garbage();
    ans_ex         = 16'($urandom);
    DM_data        = 16'($urandom);
    mem_en_ex      = 1'($urandom);
    mem_rw_ex      = 1'($urandom);
    mem_byte_ex    = 1'($urandom);
    mem_mux_sel_dm = 1'($urandom);
  endtask

  task automatic idle_cycle(input logic [15:0] v);
    exp_t e;
    garbage();
    mem_en_ex = 1'b0;
    ans_ex    = v;
    e.v = v;
    e.f = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
    check("busy_pass", {15'd0, dm_busy}, 16'd0);
  endtask

  task automatic access(input logic rw, input logic byt, input logic sel,
                        input logic [15:0] a, input logic [15:0] d);
    exp_t        e;
    logic [7:0]  idx;
    logic [15:0] word;
    idx  = a[8:1];
    word = mem[idx];
    ans_ex = a; DM_data = d; mem_en_ex = 1'b1;
    mem_rw_ex = rw; mem_byte_ex = byt; mem_mux_sel_dm = sel;
    e.f = is_fault(a, byt);
    if (e.f) begin
      e.v = 16'h0000;
    end else if (rw) begin
      e.v = a;
      if (!byt)       mem[idx] = d;
      else if (a[0])  mem[idx] = {d[7:0], word[7:0]};
      else            mem[idx] = {word[15:8], d[7:0]};
    end else if (!sel) begin
      e.v = a;
    end else if (byt) begin
      e.v = a[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
    end else begin
      e.v = word;
    end
    q.push_back(e);
    @(posedge clk);
    for (int i = 0; i <= c_wait; i++) begin
      #1;
      check("busy_high", {15'd0, dm_busy}, 16'd1);
      garbage();
      @(posedge clk);
    end
    #1;
    check("busy_low", {15'd0, dm_busy}, 16'd0);
  endtask

  task automatic check_reset_state();
    check("rst_ans_dm", ans_dm, 16'h0000);
    check("rst_valid", {15'd0, dm_valid}, 16'd0);
    check("rst_busy", {15'd0, dm_busy}, 16'd0);
    check("rst_fault", {15'd0, dm_fault}, 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Known contents everywhere so every later read has a defined answer
    for (int i = 0; i < 256; i++) begin
      access(1'b1, 1'b0, 1'b0, 16'(i << 1), 16'($urandom));
    end

    // Word write / read back
    access(1'b1, 1'b0, 1'b0, 16'h0004, 16'hFFFF);
    access(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000);
    // Byte write to the upper lane, then word and byte reads
    access(1'b1, 1'b1, 1'b0, 16'h0005, 16'h00AB);
    access(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000);
    access(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0000);
    access(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000);
    // Read with mux select low returns the address
    access(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000);
    // Pass-through
    idle_cycle(16'h0003);
    idle_cycle(16'hBEEF);

    // Reset during WAIT discards the write
    access(1'b1, 1'b0, 1'b0, 16'h0008, 16'h5A5A);
    ans_ex = 16'h0008; DM_data = 16'h1234; mem_en_ex = 1'b1;
    mem_rw_ex = 1'b1; mem_byte_ex = 1'b0; mem_mux_sel_dm = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_en_ex = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();
    access(1'b0, 1'b0, 1'b1, 16'h0008, 16'h0000);

    // Misaligned word read and out-of-range address (fault or wrap)
    access(1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000);
    access(1'b1, 1'b0, 1'b0, 16'h0207, 16'hC0DE);
    access(1'b0, 1'b0, 1'b1, 16'h0006, 16'h0000);

    // Random mix
    for (int n = 0; n < 300; n++) begin
      int          k;
      logic [15:0] a;
      k = int'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else                           a = {7'd0, 9'($urandom)};
      if (k <= 2)      idle_cycle(16'($urandom));
      else if (k <= 5) access(1'b0, 1'($urandom), 1'($urandom), a, 16'($urandom));
      else             access(1'b1, 1'($urandom), 1'($urandom), a, 16'($urandom));
    end

    @(negedge clk);
    #1;
    check("queue_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
